// File: rtl/addr_resolver_if.sv
// Request/response and pointer-memory signals of the address resolver.
// Also holds the shared AM3_* addressing-mode encodings.

`ifndef AM3_IMM
`define AM3_IMM   3'd0
`define AM3_ZPG   3'd1
`define AM3_ZPG_X 3'd2
`define AM3_ABS   3'd3
`define AM3_ABS_X 3'd4
`define AM3_ABS_Y 3'd5
`define AM3_X_IND 3'd6
`define AM3_IND_Y 3'd7
`endif

interface addr_resolver_if #(
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                  start;
  logic [2:0]            add_mode;
  logic [ADDR_WIDTH-1:0] operand;
  logic [REG_WIDTH-1:0]  x_reg;
  logic [REG_WIDTH-1:0]  y_reg;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd;
  logic [REG_WIDTH-1:0]  mem_data;
  logic [ADDR_WIDTH-1:0] eff_addr;
  logic                  is_imm;
  logic                  page_cross;
  logic                  busy;
  logic                  done;

  // fetcher + memory side
  modport master (
    output start, add_mode, operand, x_reg, y_reg, mem_data,
    input  mem_addr, mem_rd, eff_addr, is_imm, page_cross, busy, done
  );

  // resolver side
  modport slave (
    input  start, add_mode, operand, x_reg, y_reg, mem_data,
    output mem_addr, mem_rd, eff_addr, is_imm, page_cross, busy, done
  );
endinterface

// File: rtl/addr_resolver.sv
// Effective-address resolver for 6502-style addressing modes.
// Direct modes resolve in one CALC cycle; indirect modes read a two-byte
// zero-page pointer (PTR_LO, PTR_HI) and finish in DONE.
// Optional feature: define PAGE_CROSS_EN to enable the page_cross flag;
// otherwise page_cross is tied low.

module addr_resolver #(
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  addr_resolver_if.slave bus
);
  localparam int HI_W = ADDR_WIDTH - REG_WIDTH;

  typedef enum logic [2:0] {IDLE, CALC, PTR_LO, PTR_HI, DONE} state_t;

  state_t                state, state_n;
  logic [2:0]            mode_q;
  logic [ADDR_WIDTH-1:0] op_q;
  logic [REG_WIDTH-1:0]  idx_q;
  logic [REG_WIDTH-1:0]  ptr_q;
  logic [REG_WIDTH-1:0]  lo_q;
  logic [ADDR_WIDTH-1:0] res_q;
  logic                  imm_q;

  logic                  ptr_req, ptr_mode, use_y;
  logic [REG_WIDTH-1:0]  req_lo;
  logic [ADDR_WIDTH-1:0] calc_res, ptr_base, ptr_res;

  assign req_lo   = bus.operand[REG_WIDTH-1:0];
  assign ptr_req  = (bus.add_mode == `AM3_X_IND) || (bus.add_mode == `AM3_IND_Y);
  assign use_y    = (bus.add_mode == `AM3_ABS_Y) || (bus.add_mode == `AM3_IND_Y);
  assign ptr_mode = (mode_q == `AM3_X_IND) || (mode_q == `AM3_IND_Y);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // next state and pointer-read strobe/address
  always_comb begin
    state_n      = state;
    bus.mem_rd   = 1'b0;
    bus.mem_addr = '0;
    case (state)
      IDLE:   if (bus.start) state_n = ptr_req ? PTR_LO : CALC;
      CALC:   state_n = DONE;
      PTR_LO: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = {{HI_W{1'b0}}, ptr_q};
        state_n      = PTR_HI;
      end
      PTR_HI: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = {{HI_W{1'b0}}, ptr_q + REG_WIDTH'(1)};  // wraps inside page zero
        state_n      = DONE;
      end
      DONE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // direct-mode result from the captured request
  always_comb begin
    calc_res = op_q;
    case (mode_q)
      `AM3_ZPG:   calc_res = {{HI_W{1'b0}}, op_q[REG_WIDTH-1:0]};
      `AM3_ZPG_X: calc_res = {{HI_W{1'b0}}, op_q[REG_WIDTH-1:0] + idx_q};
      `AM3_ABS_X,
      `AM3_ABS_Y: calc_res = op_q + {{HI_W{1'b0}}, idx_q};
      default:    calc_res = op_q;
    endcase
  end

  // high pointer byte arrives on mem_data during DONE, so the indirect result
  // is formed there and passed straight through while done is high
  assign ptr_base = ADDR_WIDTH'({bus.mem_data, lo_q});
  assign ptr_res  = (mode_q == `AM3_IND_Y) ? ptr_base + {{HI_W{1'b0}}, idx_q} : ptr_base;

  // request capture, pointer low byte and held result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= '0;
      op_q   <= '0;
      idx_q  <= '0;
      ptr_q  <= '0;
      lo_q   <= '0;
      res_q  <= '0;
      imm_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          mode_q <= bus.add_mode;
          op_q   <= bus.operand;
          idx_q  <= use_y ? bus.y_reg : bus.x_reg;
          ptr_q  <= (bus.add_mode == `AM3_X_IND) ? req_lo + bus.x_reg : req_lo;
        end
        CALC: begin
          res_q <= calc_res;
          imm_q <= (mode_q == `AM3_IMM);
        end
        PTR_HI: begin
          lo_q  <= bus.mem_data;
          imm_q <= 1'b0;
        end
        DONE: if (ptr_mode) res_q <= ptr_res;
        default: ;
      endcase
    end
  end

  assign bus.eff_addr = (state == DONE && ptr_mode) ? ptr_res : res_q;
  assign bus.is_imm   = imm_q;
  assign bus.done     = (state == DONE);
  assign bus.busy     = (state != IDLE);

`ifdef PAGE_CROSS_EN
  logic pc_q, calc_pc, ptr_pc;

  assign calc_pc = ((mode_q == `AM3_ABS_X) || (mode_q == `AM3_ABS_Y)) &&
                   (calc_res[ADDR_WIDTH-1:REG_WIDTH] != op_q[ADDR_WIDTH-1:REG_WIDTH]);
  assign ptr_pc  = (mode_q == `AM3_IND_Y) &&
                   (ptr_res[ADDR_WIDTH-1:REG_WIDTH] != ptr_base[ADDR_WIDTH-1:REG_WIDTH]);

  // page-cross flag, updated alongside the result
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         pc_q <= 1'b0;
    else if (state == CALC)            pc_q <= calc_pc;
    else if (state == DONE && ptr_mode) pc_q <= ptr_pc;
  end

  assign bus.page_cross = (state == DONE && ptr_mode) ? ptr_pc : pc_q;
`else
  assign bus.page_cross = 1'b0;
`endif

endmodule

// File: tb/tb_addr_resolver.sv
// Self-checking bench for addr_resolver: directed vector table, hand-written
// back-to-back and busy/reset sequences, then random requests against a
// behavioural model working on integer arithmetic over a zero-page array.

`ifndef AM3_IMM
`define AM3_IMM   3'd0
`define AM3_ZPG   3'd1
`define AM3_ZPG_X 3'd2
`define AM3_ABS   3'd3
`define AM3_ABS_X 3'd4
`define AM3_ABS_Y 3'd5
`define AM3_X_IND 3'd6
`define AM3_IND_Y 3'd7
`endif

module tb_addr_resolver;
`ifdef PAGE_CROSS_EN
  localparam bit PC_EN = 1'b1;
`else
  localparam bit PC_EN = 1'b0;
`endif

  logic clk, reset;
  addr_resolver_if #(.REG_WIDTH(8), .ADDR_WIDTH(16)) bus ();

  addr_resolver #(.REG_WIDTH(8), .ADDR_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int dbl   = 0;
  logic prev_done = 1'b0;

  logic [7:0]  mem [256];
  logic [15:0] rd_log [$];

  // memory: data one cycle after the strobe; log every pointer read
  always @(posedge clk) begin
    bus.mem_data <= bus.mem_rd ? mem[bus.mem_addr[7:0]] : 8'h00;
    if (bus.mem_rd) rd_log.push_back(bus.mem_addr);
  end

  // done must never stay high two cycles in a row
  always @(negedge clk) begin
    if (bus.done && prev_done) dbl++;
    prev_done = bus.done;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // issue one request and wait for done; lat = cycles from sample edge to done
  task automatic run_req(input logic [2:0] m, input logic [15:0] op, input logic [7:0] x,
                         input logic [7:0] y, output logic [15:0] eff, output logic imm,
                         output logic pc, output int lat);
    eff = '0; imm = 1'b0; pc = 1'b0; lat = -1;
    @(negedge clk);
    rd_log.delete();
    bus.start = 1'b1; bus.add_mode = m; bus.operand = op; bus.x_reg = x; bus.y_reg = y;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = k; eff = bus.eff_addr; imm = bus.is_imm; pc = bus.page_cross;
        break;
      end
    end
  endtask

  // reference model straight from the addressing-mode rules
  function automatic void model(input logic [2:0] m, input logic [15:0] op, input logic [7:0] x,
                                input logic [7:0] y, output logic [15:0] eff, output logic imm,
                                output logic pc, output int lat);
    int lo, p, base, r;
    lo = int'(op[7:0]); imm = 1'b0; pc = 1'b0; lat = 2; r = int'(op);
    case (m)
      `AM3_IMM:   begin r = int'(op); imm = 1'b1; end
      `AM3_ZPG:   r = lo;
      `AM3_ZPG_X: r = (lo + int'(x)) % 256;
      `AM3_ABS:   r = int'(op);
      `AM3_ABS_X, `AM3_ABS_Y: begin
        r  = (int'(op) + int'((m == `AM3_ABS_X) ? x : y)) % 65536;
        pc = PC_EN && (r / 256 != int'(op) / 256);
      end
      `AM3_X_IND: begin
        p = (lo + int'(x)) % 256;
        r = int'(mem[p]) + 256 * int'(mem[(p + 1) % 256]);
        lat = 3;
      end
      default: begin
        base = int'(mem[lo]) + 256 * int'(mem[(lo + 1) % 256]);
        r    = (base + int'(y)) % 65536;
        pc   = PC_EN && (r / 256 != base / 256);
        lat  = 3;
      end
    endcase
    eff = 16'(r);
  endfunction

  typedef struct {
    logic [2:0]  m;
    logic [15:0] op;
    logic [7:0]  x, y;
    logic [7:0]  pa, lo_v, hi_v;   // pointer location and contents
    logic [15:0] e_eff;
    logic        e_imm, e_pcx;     // e_pcx: crosses a page (flag only when enabled)
    int          e_lat;
  } vec_t;

  vec_t tv [9];

  initial begin
    logic [15:0] eff, meff;
    logic imm, pc, mimm, mpc, saw;
    logic [7:0] pn;
    int lat, mlat;
    logic [2:0] m;
    logic [15:0] op;
    logic [7:0] x, y;

    bus.start = 1'b0; bus.add_mode = '0; bus.operand = '0; bus.x_reg = '0; bus.y_reg = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    reset = 1'b1;

    tv[0] = '{`AM3_ZPG_X, 16'h00F0, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0010, 1'b0, 1'b0, 2};
    tv[1] = '{`AM3_ABS_Y, 16'h12F0, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 16'h1310, 1'b0, 1'b1, 2};
    tv[2] = '{`AM3_X_IND, 16'h00FE, 8'h01, 8'h00, 8'hFF, 8'h34, 8'h12, 16'h1234, 1'b0, 1'b0, 3};
    tv[3] = '{`AM3_IND_Y, 16'h0040, 8'h00, 8'h01, 8'h40, 8'hFF, 8'h20, 16'h2100, 1'b0, 1'b1, 3};
    tv[4] = '{`AM3_IMM,   16'hBEEF, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 16'hBEEF, 1'b1, 1'b0, 2};
    tv[5] = '{`AM3_ZPG,   16'h12AB, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 16'h00AB, 1'b0, 1'b0, 2};
    tv[6] = '{`AM3_ABS,   16'h1234, 8'h05, 8'h07, 8'h00, 8'h00, 8'h00, 16'h1234, 1'b0, 1'b0, 2};
    tv[7] = '{`AM3_ABS_X, 16'hFFFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b1, 2};
    tv[8] = '{`AM3_ABS_X, 16'h1000, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 16'h1005, 1'b0, 1'b0, 2};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_eff", bus.eff_addr, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_rd", bus.mem_rd, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_imm", bus.is_imm, 0);
    chk("rst_pc", bus.page_cross, 0);
    reset = 1'b0;

    // directed vectors
    foreach (tv[i]) begin
      mem[tv[i].pa] = tv[i].lo_v;
      pn = tv[i].pa + 8'd1;
      mem[pn] = tv[i].hi_v;
      run_req(tv[i].m, tv[i].op, tv[i].x, tv[i].y, eff, imm, pc, lat);
      chk($sformatf("v%0d_eff", i), eff, tv[i].e_eff);
      chk($sformatf("v%0d_imm", i), imm, tv[i].e_imm);
      chk($sformatf("v%0d_pc", i), pc, tv[i].e_pcx & PC_EN);
      chk($sformatf("v%0d_lat", i), lat, tv[i].e_lat);
      chk($sformatf("v%0d_nrd", i), rd_log.size(), (tv[i].e_lat == 3) ? 2 : 0);
      if (rd_log.size() == 2) begin
        chk($sformatf("v%0d_rd0", i), rd_log[0], {8'h00, tv[i].pa});
        chk($sformatf("v%0d_rd1", i), rd_log[1], {8'h00, pn});
      end
    end

    // IMM then ABS started in the idle cycle right after done
    run_req(`AM3_IMM, 16'hBEEF, 8'h00, 8'h00, eff, imm, pc, lat);
    chk("b2b_imm_eff", eff, 16'hBEEF);
    chk("b2b_imm_flag", imm, 1);
    chk("b2b_imm_lat", lat, 2);
    @(negedge clk);
    chk("b2b_done_low", bus.done, 0);
    chk("b2b_hold_eff", bus.eff_addr, 16'hBEEF);
    chk("b2b_hold_imm", bus.is_imm, 1);
    chk("b2b_idle", bus.busy, 0);
    bus.start = 1'b1; bus.add_mode = `AM3_ABS; bus.operand = 16'h4321;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    chk("b2b_abs_c1", bus.done, 0);
    @(negedge clk);
    chk("b2b_abs_done", bus.done, 1);
    chk("b2b_abs_eff", bus.eff_addr, 16'h4321);
    chk("b2b_abs_imm", bus.is_imm, 0);

    // start while busy is ignored, then reset during PTR_HI aborts
    @(negedge clk);
    bus.start = 1'b1; bus.add_mode = `AM3_X_IND; bus.operand = 16'h0010; bus.x_reg = 8'h00;
    @(posedge clk);
    #1 bus.add_mode = `AM3_ZPG; bus.operand = 16'h0077;   // keep start high while busy
    @(negedge clk);
    chk("busy_ptr_lo_addr", bus.mem_addr, 16'h0010);
    chk("busy_flag", bus.busy, 1);
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    chk("busy_ptr_hi_addr", bus.mem_addr, 16'h0011);
    reset = 1'b1;
    #1;
    chk("abort_eff", bus.eff_addr, 0);
    chk("abort_mem_addr", bus.mem_addr, 0);
    chk("abort_mem_rd", bus.mem_rd, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_imm", bus.is_imm, 0);
    chk("abort_pc", bus.page_cross, 0);
    saw = 1'b0;
    repeat (3) begin @(negedge clk); saw |= bus.done; end
    reset = 1'b0;
    repeat (3) begin @(negedge clk); saw |= bus.done | bus.busy; end
    chk("abort_no_done", saw, 0);
    run_req(`AM3_ZPG_X, 16'h00F0, 8'h20, 8'h00, eff, imm, pc, lat);
    chk("post_rst_eff", eff, 16'h0010);
    chk("post_rst_lat", lat, 2);

    // random requests against the model
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      m  = 3'($urandom_range(0, 7));
      op = 16'($urandom);
      x  = 8'($urandom);
      y  = 8'($urandom);
      if (n % 5 == 0) op[7:0] = 8'hFF;          // hit pointer wrap often
      model(m, op, x, y, meff, mimm, mpc, mlat);
      run_req(m, op, x, y, eff, imm, pc, lat);
      chk($sformatf("rnd%0d_m%0d_eff", n, m), eff, meff);
      chk($sformatf("rnd%0d_m%0d_imm", n, m), imm, mimm);
      chk($sformatf("rnd%0d_m%0d_pc", n, m), pc, mpc);
      chk($sformatf("rnd%0d_m%0d_lat", n, m), lat, mlat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    chk("done_width", dbl, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/addr_resolver.md
ADDR_RESOLVER -- requirements
Module: addr_resolver

Interface
REQ-001 SHALL have parameter REG_WIDTH, 8, data/index register width.
REQ-002 SHALL have parameter ADDR_WIDTH, 16, memory address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request; samples add_mode, operand, x_reg, y_reg.
REQ-006 SHALL have port add_mode  input  3  addressing mode, encoded with the shared AM3_* defines.
REQ-007 SHALL have port operand  input  16  operand bytes from fetcher: low byte [7:0], high byte [15:8].
REQ-008 SHALL have port x_reg  input  8  X index value.
REQ-009 SHALL have port y_reg  input  8  Y index value.
REQ-010 SHALL have port mem_addr  output  16  pointer-read address.
REQ-011 SHALL have port mem_rd  output  1  pointer-read strobe.
REQ-012 SHALL have port mem_data  input  8  read data, valid exactly one cycle after mem_rd.
REQ-013 SHALL have port eff_addr  output  16  resolved effective address.
REQ-014 SHALL have port is_imm  output  1  high with done when mode is AM3_IMM.
REQ-015 SHALL have port page_cross  output  1  indexed result crossed a 256-byte page.
REQ-016 SHALL have port busy  output  1  request in progress.
REQ-017 SHALL have port done  output  1  one-cycle pulse: eff_addr, is_imm and page_cross are valid.

Function
REQ-018 SHALL implement FSM states IDLE, CALC, PTR_LO, PTR_HI, DONE.
REQ-019 SHALL move from IDLE to CALC on start for AM3_ZPG, AM3_ZPG_X, AM3_ABS, AM3_ABS_X, AM3_ABS_Y and AM3_IMM.
REQ-020 SHALL move from IDLE to PTR_LO on start for AM3_X_IND and AM3_IND_Y.
REQ-021 SHALL sequence PTR_LO -> PTR_HI -> DONE, and CALC -> DONE; DONE -> IDLE unconditionally.
REQ-022 SHALL compute the result as follows:
  - ZPG: {8'h00, op_lo}.
  - ZPG_X: {8'h00, (op_lo+X) mod 256}; zero page only, no carry.
  - ABS: operand.
  - ABS_X / ABS_Y: (operand + index) mod 65536.
  - IMM: operand, with is_imm=1.
REQ-023 SHALL compute the pointer ptr as (op_lo+X) mod 256 for X_IND, or op_lo for IND_Y.
REQ-024 SHALL, in PTR_LO, drive mem_addr={8'h00,ptr} with mem_rd=1.
REQ-025 SHALL, in PTR_HI, capture the low byte and drive mem_addr={8'h00,(ptr+1) mod 256} with mem_rd=1; 8'hFF wraps to 8'h00.
REQ-026 SHALL, in DONE, capture the high byte and produce the result:
  - X_IND: eff_addr={hi,lo}.
  - IND_Y: eff_addr=({hi,lo}+Y) mod 65536.
REQ-027 SHALL assert done for exactly the one cycle in DONE, with outputs registered and held until the next done.
REQ-028 SHALL have latency from start sample edge to done high of 2 cycles for CALC modes and 3 cycles for pointer modes.
REQ-029 SHALL keep mem_rd=0 and mem_addr=16'h0000 outside PTR_LO/PTR_HI.
REQ-030 SHALL assert busy in every state except IDLE.
REQ-031 SHALL ignore start while busy; no queuing.
REQ-032 SHALL accept start in the cycle after done (IDLE), giving back-to-back throughput.
REQ-033 SHALL set page_cross=0 for all modes other than ABS_X, ABS_Y and IND_Y.

Reset
REQ-034 SHALL, while reset is high, force state IDLE and eff_addr=0, mem_addr=0, mem_rd=0, is_imm=0, page_cross=0, busy=0, done=0, with capture registers cleared.
REQ-035 SHALL abort any in-flight request on reset with no done pulse; the first start after reset release is accepted normally.

Configuration
REQ-036 SHALL, when macro PAGE_CROSS_EN is defined, set page_cross=1 for ABS_X, ABS_Y or IND_Y when the result high byte differs from the base high byte.
REQ-037 SHALL, when PAGE_CROSS_EN is not defined, tie page_cross to 0 with no page-compare logic; all other behaviour is identical.

Verification
REQ-038 SHALL cover: ZPG_X, op=16'h00F0, X=8'h20 -> eff_addr=16'h0010 and done 2 cycles after start.
REQ-039 SHALL cover: ABS_Y, op=16'h12F0, Y=8'h20 -> eff_addr=16'h1310; page_cross=1 with PAGE_CROSS_EN, 0 without.
REQ-040 SHALL cover: X_IND, op_lo=8'hFE, X=8'h01, mem[00FF]=34, mem[0000]=12 -> reads at 00FF then 0000; eff_addr=16'h1234; done at cycle 3.
REQ-041 SHALL cover: IND_Y, op_lo=8'h40, mem[0040]=FF, mem[0041]=20, Y=8'h01 -> eff_addr=16'h2100; page_cross=1 when enabled.
REQ-042 SHALL cover: start asserted during busy, then reset mid-PTR_HI -> second start ignored; all outputs 0; no done pulse.
REQ-043 SHALL cover: IMM, op=16'hBEEF, followed by ABS start in the cycle after done -> eff_addr=16'hBEEF with is_imm=1, then the ABS result 2 cycles later.
